// File: rtl/common.sv
// Shared dbus request/response types and responder constants.
package common;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [7:0] strobe_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    strobe_t     strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  localparam int DRESP_LAT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dresp_state_t;

  // True when no address bit above the word-index field is set.
  function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned idx_w);
    return (addr >> (idx_w + 32'd3)) == 64'd0;
  endfunction

endpackage

// File: rtl/dbus_sram_resp_sram_bytewe.sv
// Single-port WORDS x 64 array with byte write enables and a registered read port.
module sram_bytewe #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    be,
  input  logic [63:0]   wdata,
  input  logic          ren,
  output logic [63:0]   rdata
);

  logic [63:0] mem_r [WORDS];
  logic [63:0] rdata_r;

  // Contents are intentionally unreset so a vendor BRAM can drop in.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++) begin
      if (be[b]) begin
        mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (ren) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dbus_sram_resp.sv
// Memory-side dbus responder: one outstanding request, fixed LATENCY to data_ok.
module dbus_sram_resp
  import common::*;
#(
  parameter int WORDS   = 4096,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [DRESP_LAT_W-1:0] LOAD_CNT = DRESP_LAT_W'(LATENCY - 1);

  dresp_state_t           state_r, state_next_s;
  logic [DRESP_LAT_W-1:0] cnt_r, cnt_next_s;
  logic [63:0]            addr_r;
  strobe_t                strobe_r;
  logic                   data_ok_r;
  logic                   rd_valid_r;

  logic                   addr_ok_s;
  logic                   accept_s;
  logic                   entering_resp_s;
  logic                   cur_read_s;
  logic                   cur_in_range_s;
  logic [IDX_W-1:0]       sram_addr_s;
  logic [7:0]             sram_be_s;
  logic                   sram_ren_s;
  logic [63:0]            sram_rdata_s;
  logic                   unused_size_s;

  assign unused_size_s = ^dreq.size;

  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    addr_ok_s    = 1'b1;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_RESP: begin
        addr_ok_s = 1'b1;
        if (dreq.valid) begin
          accept_s     = 1'b1;
          cnt_next_s   = LOAD_CNT;
          state_next_s = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end else begin
          cnt_next_s   = DRESP_LAT_W'(0);
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        addr_ok_s  = 1'b0;
        cnt_next_s = cnt_r - DRESP_LAT_W'(1);
        // Leave on the edge where the counter reaches zero.
        if (cnt_r <= DRESP_LAT_W'(1)) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      default: begin
        addr_ok_s    = 1'b1;
        cnt_next_s   = DRESP_LAT_W'(0);
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // With LATENCY==1 the read is issued on the acceptance edge, so use live request fields.
  always_comb begin
    entering_resp_s = (state_next_s == ST_RESP);
    if (accept_s) begin
      cur_read_s     = (dreq.strobe == 8'd0);
      cur_in_range_s = addr_in_range(dreq.addr, IDX_W);
      sram_addr_s    = dreq.addr[3 +: IDX_W];
    end else begin
      cur_read_s     = (strobe_r == 8'd0);
      cur_in_range_s = addr_in_range(addr_r, IDX_W);
      sram_addr_s    = addr_r[3 +: IDX_W];
    end
    if (accept_s && cur_in_range_s) begin
      sram_be_s = dreq.strobe;
    end else begin
      sram_be_s = 8'd0;
    end
    sram_ren_s = entering_resp_s && cur_read_s && cur_in_range_s;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      cnt_r      <= DRESP_LAT_W'(0);
      addr_r     <= 64'd0;
      strobe_r   <= 8'd0;
      data_ok_r  <= 1'b0;
      rd_valid_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      data_ok_r <= entering_resp_s;
      if (accept_s) begin
        addr_r   <= dreq.addr;
        strobe_r <= dreq.strobe;
      end
      // Out-of-range reads present zero; writes leave the held data alone.
      if (entering_resp_s && cur_read_s) begin
        rd_valid_r <= cur_in_range_s;
      end
    end
  end

  sram_bytewe #(
    .WORDS(WORDS)
  ) u_sram (
    .clk   (clk),
    .addr  (sram_addr_s),
    .be    (sram_be_s),
    .wdata (dreq.data),
    .ren   (sram_ren_s),
    .rdata (sram_rdata_s)
  );

  assign dresp = '{
    addr_ok: addr_ok_s,
    data_ok: data_ok_r,
    data:    (rd_valid_r ? sram_rdata_s : 64'd0)
  };

endmodule

// File: tb/tb_dbus_sram_resp.sv
// Scoreboard bench: three responders at LATENCY 1, 2 and 4 driven one at a time.
module tb_dbus_sram_resp;
  import common::*;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       resetn [NI];
  dbus_req_t  dreq   [NI];
  dbus_resp_t dresp  [NI];

  typedef struct {
    int          inst;
    int          cyc;
    logic [63:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [63:0] held [NI];
  int          cyc   = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_sram_resp #(.WORDS(4096), .LATENCY(1)) u_l1 (
    .clk(clk), .resetn(resetn[0]), .dreq(dreq[0]), .dresp(dresp[0]));
  dbus_sram_resp #(.WORDS(4096), .LATENCY(2)) u_l2 (
    .clk(clk), .resetn(resetn[1]), .dreq(dreq[1]), .dresp(dresp[1]));
  dbus_sram_resp #(.WORDS(4096), .LATENCY(4)) u_l4 (
    .clk(clk), .resetn(resetn[2]), .dreq(dreq[2]), .dresp(dresp[2]));

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every data_ok must match the oldest expected response.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (dresp[i].data_ok === 1'b1) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_data_ok: inst %0d cycle %0d got data_ok=1 expected 0", i, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check("resp_inst", 64'(i), 64'(mon_e.inst));
          check("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("resp_data", dresp[i].data, mon_e.data);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
  task automatic issue(input int i, input logic [63:0] addr, input logic [7:0] strb,
                       input logic [63:0] wd, input logic [63:0] exp_rd, input bit track,
                       output int waits);
    dreq[i].valid  = 1'b1;
    dreq[i].addr   = addr;
    dreq[i].size   = MSIZE8;
    dreq[i].strobe = strb;
    dreq[i].data   = wd;
    waits = 0;
    while (dresp[i].addr_ok !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: inst %0d addr_ok got 0 expected 1 within 50 cycles", i);
    end else begin
      if (strb == 8'd0) held[i] = exp_rd;
      if (track) sb_q.push_back('{i, cyc + lat_of(i), held[i]});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int i);
    dreq[i] = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int w;
    for (int i = 0; i < NI; i++) begin
      resetn[i] = 1'b0;
      dreq[i]   = '0;
      held[i]   = 64'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_addr_ok", 64'(dresp[i].addr_ok), 64'd1);
      check("rst_data_ok", 64'(dresp[i].data_ok), 64'd0);
      check("rst_data", dresp[i].data, 64'd0);
      resetn[i] = 1'b1;
    end
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check("idle_addr_ok", 64'(dresp[i].addr_ok), 64'd1);
        check("idle_data", dresp[i].data, 64'd0);
      end
    end

    // Full write then read, then partial strobe, LATENCY 2
    issue(1, 64'h80, 8'hFF, 64'h1122334455667788, 64'h0, 1'b1, w);
    issue(1, 64'h80, 8'h00, 64'h0, 64'h1122334455667788, 1'b1, w);
    issue(1, 64'h80, 8'h0F, 64'hAAAAAAAA_DEADBEEF, 64'h0, 1'b1, w);
    issue(1, 64'h80, 8'h00, 64'h0, 64'h11223344DEADBEEF, 1'b1, w);
    idle(1);
    drain();

    // Out of range: 0x8000 must not alias onto word 0
    issue(1, 64'h0, 8'hFF, 64'h0123456789ABCDEF, 64'h0, 1'b1, w);
    issue(1, 64'h8000, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, w);
    issue(1, 64'h8000, 8'h00, 64'h0, 64'h0, 1'b1, w);
    issue(1, 64'h0, 8'h00, 64'h0, 64'h0123456789ABCDEF, 1'b1, w);
    idle(1);
    drain();

    // Back-to-back at LATENCY 1: every request accepted without waiting
    issue(0, 64'h200, 8'hFF, 64'hA5A5A5A5_5A5A5A5A, 64'h0, 1'b1, w);
    check("b2b_wait0", 64'(w), 64'd0);
    issue(0, 64'h200, 8'h00, 64'h0, 64'hA5A5A5A5_5A5A5A5A, 1'b1, w);
    check("b2b_wait1", 64'(w), 64'd0);
    issue(0, 64'h208, 8'hFF, 64'h0F1E2D3C_4B5A6978, 64'h0, 1'b1, w);
    check("b2b_wait2", 64'(w), 64'd0);
    issue(0, 64'h208, 8'h00, 64'h0, 64'h0F1E2D3C_4B5A6978, 1'b1, w);
    check("b2b_wait3", 64'(w), 64'd0);
    idle(0);
    drain();

    // Reset mid-flight at LATENCY 4
    issue(2, 64'h100, 8'hFF, 64'hCAFEBABE_00C0FFEE, 64'h0, 1'b1, w);
    issue(2, 64'h100, 8'h00, 64'h0, 64'hCAFEBABE_00C0FFEE, 1'b1, w);
    idle(2);
    drain();
    issue(2, 64'h100, 8'h00, 64'h0, 64'h0, 1'b0, w);
    idle(2);
    @(negedge clk);
    resetn[2] = 1'b0;
    #1;
    check("midrst_addr_ok", 64'(dresp[2].addr_ok), 64'd1);
    check("midrst_data_ok", 64'(dresp[2].data_ok), 64'd0);
    check("midrst_data", dresp[2].data, 64'd0);
    @(negedge clk);
    resetn[2] = 1'b1;
    held[2]   = 64'd0;
    repeat (6) @(negedge clk);
    issue(2, 64'h100, 8'h00, 64'h0, 64'hCAFEBABE_00C0FFEE, 1'b1, w);
    idle(2);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation got past 100000 time units expected to finish earlier");
    $fatal(1);
  end

endmodule
